key_debounce_arbiter: RTL

- Debounces N_KEYS raw push-button inputs using one shared debounce counter instead of one counter per key.
- A round-robin arbiter grants the counter to one key whose synchronised level differs from its committed stable level.
- Confirmed transitions update the stable vector, emit one-cycle press/release pulses and push an event into a small valid/ready event FIFO.
- Sits between the board key pins and the CPU I/O register block.

---
 rtl/key_pkg.sv | 24 ++
 rtl/key_event_fifo.sv | 101 ++++++++++
 rtl/key_debounce_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// ---------------------------------------------------------------------------
// key_pkg
// Shared definitions for the key debounce arbiter:
//   - key_state_e : debounce FSM states (idle / counting a granted key)
//   - idx_w()     : width of a key index for a given key count
//   - EV_*        : field offsets inside an event word {key index, new level}
// ---------------------------------------------------------------------------
package key_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } key_state_e;

  // Bits needed to index n keys; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Event word layout: new level in bit 0, key index above it.
  localparam int EV_LVL_BIT = 0;
  localparam int EV_IDX_LSB = 1;

endpackage

// File: rtl/key_event_fifo.sv
// ---------------------------------------------------------------------------
// key_event_fifo
// Synchronous valid/ready FIFO holding debounced key events.
// Ports:
//   clk, nrst      clock, asynchronous active-low reset
//   i_push, i_data write request and event word
//   i_ready        consumer accepts the head entry when o_valid=1
//   o_valid        FIFO non-empty (registered)
//   o_data         head entry, held while o_valid=1 and i_ready=0
//   o_full         all DEPTH entries occupied
//   o_drop         push rejected this cycle (full and no pop)
// A push into a full FIFO is accepted when the head is popped in the same
// cycle, so occupancy stays at DEPTH and nothing is lost.
// ---------------------------------------------------------------------------
module key_event_fifo
  import key_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_drop
);

  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_valid;

  logic             w_pop;
  logic             w_wr_en;
  logic             w_drop;
  logic [AW:0]      w_count_nxt;

  assign o_full  = (r_count == CNT_FULL);
  assign o_valid = r_valid;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_drop  = w_drop;

  // Accept/drop decision and next occupancy.
  always_comb begin
    w_pop       = r_valid & i_ready;
    w_wr_en     = 1'b0;
    w_drop      = 1'b0;
    w_count_nxt = r_count;
    if (i_push) begin
      if (!o_full || w_pop) begin
        w_wr_en = 1'b1;
      end else begin
        w_drop = 1'b1;
      end
    end else begin
      w_wr_en = 1'b0;
    end
    if (w_wr_en && !w_pop) begin
      w_count_nxt = r_count + CNT_ONE;
    end else if (!w_wr_en && w_pop) begin
      w_count_nxt = r_count - CNT_ONE;
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Storage, pointers, occupancy and the registered valid flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_wr_en) begin
        // When full with a pop this slot is the outgoing head, so reuse is safe.
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

endmodule

// File: rtl/key_debounce_arbiter.sv
// ---------------------------------------------------------------------------
// key_debounce_arbiter
// Debounces N_KEYS raw push-buttons with a single shared counter. A
// round-robin arbiter hands the counter to one key whose synchronised level
// disagrees with its committed level; if the disagreement lasts
// DEBOUNCE_CYCLES the new level is committed, a press/release pulse is
// emitted and an event {key index, new level} is queued for the CPU.
// Ports:
//   clk, nrst        clock, asynchronous active-low reset
//   key_raw          asynchronous raw key levels, 1 = pressed
//   key_stable       committed (debounced) levels
//   press_pulse      one-cycle pulse on a committed 0->1
//   release_pulse    one-cycle pulse on a committed 1->0
//   ev_valid         event queue non-empty
//   ev_data          head event {key index, new level}
//   ev_ready         consumer accepts the head event
//   ev_overflow      sticky: an event was dropped on a full queue
//   ovf_clr          clears ev_overflow (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module key_debounce_arbiter
  import key_pkg::*;
#(
  parameter int  N_KEYS          = 8,
  parameter int  DEBOUNCE_CYCLES = 1_000_000,
  parameter int  CNT_W           = 21,
  parameter int  EV_DEPTH        = 4,
  localparam int IDX_W           = idx_w(N_KEYS)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_stable,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic              ev_valid,
  output logic [IDX_W:0]    ev_data,
  input  logic              ev_ready,
  output logic              ev_overflow,
  input  logic              ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W-1:0] RR_INIT  = IDX_W'(N_KEYS - 1);
  localparam logic [N_KEYS-1:0] KEY_ONE = N_KEYS'(1);

  // Synchroniser and committed state
  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] r_stable;
  logic [N_KEYS-1:0] r_press;
  logic [N_KEYS-1:0] r_release;
  logic              r_ovf;

  // Arbiter / FSM state
  key_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_grant;
  logic [IDX_W-1:0]  r_rr_ptr;

  // Combinational next values
  logic [N_KEYS-1:0] w_mism;
  logic [N_KEYS-1:0] w_onehot;
  logic              w_found;
  logic              w_hit;
  logic [IDX_W-1:0]  w_cand;
  logic [IDX_W-1:0]  w_search_idx;
  key_state_e        w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [IDX_W-1:0]  w_grant_nxt;
  logic [IDX_W-1:0]  w_rr_nxt;
  logic              w_commit;
  logic [N_KEYS-1:0] w_stable_nxt;
  logic [N_KEYS-1:0] w_press_nxt;
  logic [N_KEYS-1:0] w_release_nxt;
  logic [IDX_W:0]    w_ev_wdata;
  logic              w_drop;
  logic              w_ovf_nxt;
  logic              w_fifo_full;

  assign w_mism   = r_sync2 ^ r_stable;
  assign w_onehot = KEY_ONE << r_grant;

  // Round-robin search: first mismatching key after the last serviced one, wrapping.
  always_comb begin
    w_found      = 1'b0;
    w_hit        = 1'b0;
    w_cand       = '0;
    w_search_idx = '0;
    for (int i = 1; i <= N_KEYS; i++) begin
      w_cand       = IDX_W'((int'(r_rr_ptr) + i) % N_KEYS);
      w_hit        = !w_found && w_mism[w_cand];
      w_search_idx = w_hit ? w_cand : w_search_idx;
      w_found      = w_found | w_hit;
    end
  end

  // FSM next state, shared counter, grant latch and round-robin pointer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_rr_nxt    = r_rr_ptr;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_search_idx;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_COUNT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_COUNT: begin
        w_cnt_nxt = r_cnt + CNT_ONE;
        // A bounce back to the committed level beats a commit on the same cycle.
        if (!w_mism[r_grant]) begin
          w_state_nxt = ST_IDLE;
          w_rr_nxt    = r_grant;
        end else if (r_cnt == CNT_LAST) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_IDLE;
          w_rr_nxt    = r_grant;
        end else begin
          w_state_nxt = ST_COUNT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Commit effects: flip the granted key, form its pulse and the event word.
  always_comb begin
    w_stable_nxt  = r_stable;
    w_press_nxt   = '0;
    w_release_nxt = '0;
    w_ev_wdata    = '0;
    w_ev_wdata[EV_IDX_LSB +: IDX_W] = r_grant;
    w_ev_wdata[EV_LVL_BIT]          = ~r_stable[r_grant];
    if (w_commit) begin
      w_stable_nxt  = r_stable ^ w_onehot;
      w_press_nxt   = w_onehot & ~r_stable;
      w_release_nxt = w_onehot & r_stable;
    end else begin
      w_stable_nxt  = r_stable;
    end
  end

  // Sticky overflow: a drop in the same cycle overrides a clear request.
  always_comb begin
    if (w_drop) begin
      w_ovf_nxt = 1'b1;
    end else if (ovf_clr) begin
      w_ovf_nxt = 1'b0;
    end else begin
      w_ovf_nxt = r_ovf;
    end
  end

  // Two-flop synchroniser for the asynchronous key pins.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
    end
  end

  // FSM and arbiter registers; reset discards any debounce in progress.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_grant  <= '0;
      r_rr_ptr <= RR_INIT;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Committed levels, pulses and overflow flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_stable  <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_stable  <= w_stable_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  key_event_fifo #(
    .WIDTH (IDX_W + 1),
    .DEPTH (EV_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .i_push  (w_commit),
    .i_data  (w_ev_wdata),
    .i_ready (ev_ready),
    .o_valid (ev_valid),
    .o_data  (ev_data),
    .o_full  (w_fifo_full),
    .o_drop  (w_drop)
  );

  assign key_stable    = r_stable;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign ev_overflow   = r_ovf;

endmodule
